// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one line-granular memory port between the
// instruction cache and the data cache.
module cache_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256,
  parameter logic [31:0] COUNT_INIT = 32'd0  // reset value of conflict_count (0 in normal use)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       conflict_count
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  SERVE_I   = 2'd1;
  localparam logic [1:0]  SERVE_D   = 2'd2;
  localparam logic        GRANT_I   = 1'b0;
  localparam logic        GRANT_D   = 1'b1;
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Read data is a straight pass-through; the resp pulse qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, grant decision and Moore memory-port outputs.
  always_comb begin
    state_next   = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        grant_i = i_req && (!d_req || last_grant == GRANT_D);
        grant_d = d_req && !grant_i;
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_resp       = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      SERVE_D: begin
        pmem_read    = !write_q;
        pmem_write   = write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        d_resp       = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture on the grant edge; a simultaneous read+write is a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else if (grant_i) begin
      last_grant <= GRANT_I;
      addr_q     <= i_address;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else if (grant_d) begin
      last_grant <= GRANT_D;
      addr_q     <= d_address;
      wdata_q    <= d_write ? d_wdata : '0;
      write_q    <= d_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count <= COUNT_INIT;
    end else if (state == IDLE && i_req && d_req && conflict_count != COUNT_MAX) begin
      conflict_count <= conflict_count + 32'd1;
    end
  end

  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");

endmodule
